regfile_param: RTL and testbench

Parametrised multi-port integer register file for the RISC-V Lite core. It replaces the fixed 32×32, two-read-port register file and adds three things: a configurable read-port count, a per-register busy scoreboard for multicycle/pipelined write-back, and a post-reset scrub sequencer. Storage has no reset, so it can map to RAM or latch arrays. The block sits between decode (read/issue) and write-back.

---
 rtl/regfile_param.sv | 165 ++++++++++++++++
 tb/tb_regfile_param.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// regfile_param: multi-port integer register file with a per-register
// busy scoreboard and a post-reset scrub sequencer.
//
// Parameters:
//   XLEN  data width
//   NREG  architectural registers (power of two, >= 4), x0 reads as zero
//   NRD   read ports (1..4)
//   AW    address width, derived from NREG
// Ports:
//   clk       clock, rising edge
//   RST       asynchronous active-high reset
//   en        global write/issue qualifier (stall when low)
//   rd_addr   NRD packed read addresses, port k at [k*AW +: AW]
//   rd_data   NRD packed read data, combinational
//   rd_busy   busy flag of each addressed register
//   wr_en     write-back strobe
//   wr_addr   write-back destination
//   wr_data   write-back data
//   issue_en  issue strobe, marks issue_rd busy
//   issue_rd  destination register of the issuing instruction
//   ready     scrub complete, file usable
//
// Optional feature:
//   RF_BYPASS_EN  forwards same-cycle write data to matching read ports.
module regfile_param #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                RST,
  input  logic                en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_rd,
  output logic                ready
);

  typedef enum logic {
    S_SCRUB,
    S_READY
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);
  localparam logic [AW-1:0] FIRST = AW'(1);

  state_t state_q, state_d;
  logic [AW-1:0] sc_q, sc_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic scrub_we;

  // Storage deliberately carries no reset so it can map onto RAM.
  logic [XLEN-1:0] mem [NREG];

  logic we;
  logic ie;

  assign ready = (state_q == S_READY);

  assign we = wr_en & en & ready
            & (wr_addr != '0);
  assign ie = issue_en & en & ready
            & (issue_rd != '0);

  // Scrub sequencer: walks x1..x(NREG-1) once after reset.
  always_comb begin
    state_d  = state_q;
    sc_d     = sc_q;
    scrub_we = 1'b0;
    unique case (state_q)
      S_SCRUB: begin
        scrub_we = 1'b1;
        sc_d     = sc_q + FIRST;
        if (sc_q == LAST) begin
          state_d = S_READY;
          sc_d    = sc_q;
        end
      end
      S_READY: begin
        sc_d = sc_q;
      end
      default: begin
        state_d = S_SCRUB;
        sc_d    = FIRST;
      end
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= S_SCRUB;
      sc_q    <= FIRST;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
    end
  end

  // Scrub and write-back never overlap: we needs ready.
  always_ff @(posedge clk) begin
    if (scrub_we) begin
      mem[sc_q] <= '0;
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Set after clear: a same-cycle issue means a newer
  // producer is already in flight.
  always_comb begin
    busy_d = busy_q;
    if (we) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (ie) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdat;
    logic            rbsy;

    assign ra = rd_addr[k*AW +: AW];

    always_comb begin
      rdat = '0;
      rbsy = 1'b0;
      if (ready && (ra != '0)) begin
`ifdef RF_BYPASS_EN
        if (we && (ra == wr_addr)) begin
          rdat = wr_data;
          rbsy = ie && (issue_rd == ra);
        end else begin
          rdat = mem[ra];
          rbsy = busy_q[ra];
        end
`else
        rdat = mem[ra];
        rbsy = busy_q[ra];
`endif
      end
    end

    assign rd_data[k*XLEN +: XLEN] = rdat;
    assign rd_busy[k] = rbsy;
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: randomized self-checking bench for regfile_param
// against an array-based reference model.
module tb_regfile_param;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                RST = 1'b0;
  logic                en = 1'b1;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en = 1'b0;
  logic [AW-1:0]       wr_addr = '0;
  logic [XLEN-1:0]     wr_data = '0;
  logic                issue_en = 1'b0;
  logic [AW-1:0]       issue_rd = '0;
  logic                ready;

  always #5 clk = ~clk;

  regfile_param #(
    .XLEN(XLEN),
    .NREG(NREG),
    .NRD (NRD)
  ) dut (
    .clk     (clk),
    .RST     (RST),
    .en      (en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_busy (rd_busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .issue_en(issue_en),
    .issue_rd(issue_rd),
    .ready   (ready)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [XLEN-1:0] m_mem [NREG];
  bit              m_busy [NREG];
  bit              m_ready;
  int              m_edges;

  function automatic bit f_we();
    return wr_en && en && m_ready
        && (wr_addr != 0);
  endfunction

  function automatic bit f_ie();
    return issue_en && en && m_ready
        && (issue_rd != 0);
  endfunction

  function automatic logic [XLEN-1:0]
      exp_data(int k);
    logic [AW-1:0] a;
    a = rd_addr[k*AW +: AW];
    if (!m_ready || a == 0) return '0;
`ifdef RF_BYPASS_EN
    if (f_we() && a == wr_addr)
      return wr_data;
`endif
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(int k);
    logic [AW-1:0] a;
    a = rd_addr[k*AW +: AW];
    if (!m_ready || a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
    if (f_we() && a == wr_addr)
      return f_ie() && issue_rd == a;
`endif
    return m_busy[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_ready = 1'b0;
    m_edges = 0;
  endtask

  task automatic tick();
    bit we, ie;
    logic [AW-1:0] wa, ir;
    logic [XLEN-1:0] wd;
    we = f_we();
    ie = f_ie();
    wa = wr_addr;
    ir = issue_rd;
    wd = wr_data;
    @(posedge clk);
    if (we) begin
      m_mem[wa]  = wd;
      m_busy[wa] = 1'b0;
    end
    if (ie) m_busy[ir] = 1'b1;
    if (!m_ready) begin
      m_edges++;
      if (m_edges == NREG - 1)
        m_ready = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    issue_en = 1'b0;
    en       = 1'b1;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    model_clear();
    @(posedge clk);
    #3;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready got=%b exp=0",
               ready);
    end
    for (int i = 1; i <= NREG - 1; i++) begin
      wr_en    = 1'($urandom);
      wr_addr  = AW'($urandom);
      wr_data  = $urandom;
      issue_en = 1'($urandom);
      issue_rd = AW'($urandom);
      tick();
      n_checks++;
      if (ready !== (i == NREG - 1)) begin
        n_fail++;
        $display("FAIL scrub_ready edge=%0d got=%b exp=%b",
                 i, ready, (i == NREG - 1));
      end
    end
    idle();
    for (int a = 0; a < NREG; a += 2) begin
      rd_addr = {AW'(a + 1), AW'(a)};
      #1;
      n_checks++;
      if (rd_data !== '0 || rd_busy !== '0) begin
        n_fail++;
        $display("FAIL scrub_zero x%0d got=%h/%b exp=0/0",
                 a, rd_data, rd_busy);
      end
    end
  endtask

  task automatic test_write_read();
    wr_en   = 1'b1;
    wr_addr = 5;
    wr_data = 32'hDEADBEEF;
    tick();
    wr_en   = 1'b0;
    rd_addr = {AW'(0), AW'(5)};
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF
        || rd_data[63:32] !== '0) begin
      n_fail++;
      $display("FAIL wr_x5 got=%h exp=%h",
               rd_data, {32'h0, 32'hDEADBEEF});
    end
    wr_en   = 1'b1;
    wr_addr = 0;
    wr_data = 32'h1234;
    tick();
    wr_en   = 1'b0;
    rd_addr = {AW'(0), AW'(0)};
    #1;
    n_checks++;
    if (rd_data !== '0) begin
      n_fail++;
      $display("FAIL wr_x0 got=%h exp=0", rd_data);
    end
  endtask

  task automatic test_scoreboard();
    int ones;
    int exp_ones;
    idle();
    issue_en = 1'b1;
    issue_rd = 7;
    rd_addr  = {AW'(0), AW'(7)};
    tick();
    issue_en = 1'b0;
    ones = 0;
    for (int j = 0; j < 5; j++) begin
      wr_en   = (j == 2);
      wr_addr = 7;
      wr_data = $urandom;
      #1;
      if (rd_busy[0] === 1'b1) ones++;
      n_checks++;
      if (rd_busy[0] !== exp_busy(0)) begin
        n_fail++;
        $display("FAIL busy_x7 j=%0d got=%b exp=%b",
                 j, rd_busy[0], exp_busy(0));
      end
      tick();
    end
    wr_en = 1'b0;
`ifdef RF_BYPASS_EN
    exp_ones = 2;
`else
    exp_ones = 3;
`endif
    n_checks++;
    if (ones != exp_ones) begin
      n_fail++;
      $display("FAIL busy_len got=%0d exp=%0d",
               ones, exp_ones);
    end
    issue_en = 1'b1;
    issue_rd = 9;
    wr_en    = 1'b1;
    wr_addr  = 9;
    wr_data  = 32'h0909;
    tick();
    idle();
    rd_addr = {AW'(9), AW'(9)};
    #1;
    n_checks++;
    if (rd_busy !== 2'b11
        || rd_data !== {2{32'h0909}}) begin
      n_fail++;
      $display("FAIL set_wins got=%b/%h exp=11/%h",
               rd_busy, rd_data, {2{32'h0909}});
    end
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] exp;
    wr_en   = 1'b1;
    wr_addr = 3;
    wr_data = 32'h11111111;
    tick();
    wr_data = 32'hA5A5A5A5;
    rd_addr = {AW'(0), AW'(3)};
    #1;
`ifdef RF_BYPASS_EN
    exp = 32'hA5A5A5A5;
`else
    exp = 32'h11111111;
`endif
    n_checks++;
    if (rd_data[31:0] !== exp
        || rd_data[31:0] !== exp_data(0)) begin
      n_fail++;
      $display("FAIL bypass_same got=%h exp=%h",
               rd_data[31:0], exp);
    end
    tick();
    wr_en = 1'b0;
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL bypass_next got=%h exp=a5a5a5a5",
               rd_data[31:0]);
    end
  endtask

  task automatic test_stall();
    wr_en   = 1'b1;
    wr_addr = 4;
    wr_data = 32'h99;
    tick();
    en      = 1'b0;
    wr_data = 32'h55;
    rd_addr = {AW'(4), AW'(4)};
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (rd_data[31:0] !== 32'h99) begin
        n_fail++;
        $display("FAIL stall_hold got=%h exp=99",
                 rd_data[31:0]);
      end
    end
    en = 1'b1;
    tick();
    wr_en = 1'b0;
    #1;
    n_checks++;
    if (rd_data[63:32] !== 32'h55) begin
      n_fail++;
      $display("FAIL stall_release got=%h exp=55",
               rd_data[63:32]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rd_addr  = NRD*AW'($urandom);
      wr_en    = 1'($urandom);
      wr_addr  = AW'($urandom);
      wr_data  = $urandom;
      issue_en = 1'($urandom);
      issue_rd = AW'($urandom);
      en       = ($urandom % 8) != 0;
      #1;
      for (int k = 0; k < NRD; k++) begin
        n_checks++;
        if (rd_data[k*XLEN +: XLEN] !== exp_data(k)
            || rd_busy[k] !== exp_busy(k)) begin
          n_fail++;
          $display("FAIL rand c=%0d port%0d got=%h/%b exp=%h/%b",
                   c, k, rd_data[k*XLEN +: XLEN],
                   rd_busy[k], exp_data(k), exp_busy(k));
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    wr_en    = 1'b1;
    wr_addr  = 6;
    wr_data  = 32'h77;
    issue_en = 1'b1;
    issue_rd = 6;
    tick();
    idle();
    rd_addr = {AW'(6), AW'(6)};
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'h77
        || rd_busy !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_pre got=%h/%b exp=77/11",
               rd_data[31:0], rd_busy);
    end
    #2;
    RST = 1'b1;
    model_clear();
    #1;
    n_checks++;
    if (ready !== 1'b0 || rd_busy !== '0
        || rd_data !== '0) begin
      n_fail++;
      $display("FAIL mid_async got=%b/%b/%h exp=0/0/0",
               ready, rd_busy, rd_data);
    end
    @(posedge clk);
    #3;
    RST = 1'b0;
    for (int i = 0; i < NREG - 1; i++) tick();
    #1;
    n_checks++;
    if (ready !== 1'b1 || rd_data !== '0
        || rd_busy !== '0) begin
      n_fail++;
      $display("FAIL mid_rescrub got=%b/%h/%b exp=1/0/0",
               ready, rd_data, rd_busy);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_write_read();
    test_scoreboard();
    test_bypass();
    test_stall();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
